// File: rtl/fft4_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft4_frame_sequencer_if
// Purpose  : Bundles the sample stream, the FFT core buses, the bin stream
//            and the frame counter of fft4_frame_sequencer.
// Modports : slave  - the sequencer itself
//            master - the surrounding system (sample source, core, sink)
// Signals  : flush, in_valid/in_ready/in_re/in_im      sample stream
//            core_re_x/core_im_x (to core), core_re_X/core_im_X (from core)
//            out_valid/out_ready/out_re/out_im/out_bin/out_last  bin stream
//            frame_idx                                  completed frames
// Revision : 1.0 - initial release
// ============================================================================
interface fft4_frame_sequencer_if;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_re;
  logic [31:0]  in_im;
  logic [127:0] core_re_x;
  logic [127:0] core_im_x;
  logic [127:0] core_re_X;
  logic [127:0] core_im_X;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_re;
  logic [31:0]  out_im;
  logic [1:0]   out_bin;
  logic         out_last;
  logic [15:0]  frame_idx;

  modport slave (
    input  flush, in_valid, in_re, in_im, core_re_X, core_im_X, out_ready,
    output in_ready, core_re_x, core_im_x, out_valid, out_re, out_im,
           out_bin, out_last, frame_idx
  );

  modport master (
    output flush, in_valid, in_re, in_im, core_re_X, core_im_X, out_ready,
    input  in_ready, core_re_x, core_im_x, out_valid, out_re, out_im,
           out_bin, out_last, frame_idx
  );
endinterface
`default_nettype wire

// File: rtl/fft4_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft4_frame_sequencer
// Purpose  : Collects complex samples into 4-slot frames, holds each frame
//            on the combinational 4-point FFT core for CORE_LAT cycles,
//            captures the core results and streams bins X0..X3 out.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - fft4_frame_sequencer_if.slave (sample stream, core
//                   buses, bin stream, frame counter)
// Params   : CORE_LAT - core settle cycles, 1..15
// Config   : STFT_OVERLAP_EN - when defined, frames overlap by 50% (hop 2):
//            slots 2,3 are reused as slots 0,1 of the next frame.
//            Undefined: hop 4, every frame takes 4 fresh samples.
// Revision : 1.0 - initial release
// ============================================================================
module fft4_frame_sequencer #(
  parameter int CORE_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  fft4_frame_sequencer_if.slave         bus
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Terminal count of the settle counter; capture happens when it is reached.
  localparam logic [3:0] LAT_LAST = 4'(CORE_LAT - 1);

  state_t      state;
  logic [1:0]  fill_cnt;
  logic [3:0]  lat_cnt;
  logic [1:0]  bin;
  logic [15:0] frame_cnt;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        out_last_q;

  logic [31:0] frm_re [4];
  logic [31:0] frm_im [4];
  logic [31:0] res_re [4];
  logic [31:0] res_im [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FILL;
      fill_cnt    <= 2'd0;
      lat_cnt     <= 4'd0;
      bin         <= 2'd0;
      frame_cnt   <= 16'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        frm_re[k] <= 32'd0;
        frm_im[k] <= 32'd0;
        res_re[k] <= 32'd0;
        res_im[k] <= 32'd0;
      end
    end else begin
      case (state)
        ST_FILL: begin
          // flush has priority: the sample offered in the same cycle is dropped
          if (bus.flush) begin
            fill_cnt <= 2'd0;
          end else if (bus.in_valid) begin
            frm_re[fill_cnt] <= bus.in_re;
            frm_im[fill_cnt] <= bus.in_im;
            fill_cnt         <= fill_cnt + 2'd1;
            if (fill_cnt == 2'd3) begin
              state      <= ST_WAIT;
              lat_cnt    <= 4'd0;
              in_ready_q <= 1'b0;
            end
          end
        end

        ST_WAIT: begin
          // Frame registers are frozen here, so the core path is multicycle.
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_cnt == LAT_LAST) begin
            for (int k = 0; k < 4; k++) begin
              res_re[k] <= bus.core_re_X[32*k +: 32];
              res_im[k] <= bus.core_im_X[32*k +: 32];
            end
            bin         <= 2'd0;
            state       <= ST_DRAIN;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (bus.out_ready) begin
            bin        <= bin + 2'd1;
            out_last_q <= (bin == 2'd2);
            if (bin == 2'd3) begin
              frame_cnt   <= frame_cnt + 16'd1;
              state       <= ST_FILL;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
`ifdef STFT_OVERLAP_EN
              // Hop 2: the newer half of this frame opens the next one.
              frm_re[0] <= frm_re[2];
              frm_im[0] <= frm_im[2];
              frm_re[1] <= frm_re[3];
              frm_im[1] <= frm_im[3];
              fill_cnt  <= 2'd2;
`else
              fill_cnt  <= 2'd0;
`endif
            end
          end
        end

        default: begin
          state       <= ST_FILL;
          fill_cnt    <= 2'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_bin   = bin;
  assign bus.out_re    = res_re[bin];
  assign bus.out_im    = res_im[bin];
  assign bus.frame_idx = frame_cnt;
  assign bus.core_re_x = {frm_re[3], frm_re[2], frm_re[1], frm_re[0]};
  assign bus.core_im_x = {frm_im[3], frm_im[2], frm_im[1], frm_im[0]};

endmodule
`default_nettype wire

// File: tb/tb_fft4_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fft4_frame_sequencer
// Purpose  : Self-checking bench for fft4_frame_sequencer. A 4-point DFT
//            stands in for the core; a queue-based frame model predicts the
//            bin stream. Extra instances with CORE_LAT=1 and 15 share the
//            main stimulus for latency checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft4_frame_sequencer;

`ifdef STFT_OVERLAP_EN
  localparam int HOP = 2;
`else
  localparam int HOP = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft4_frame_sequencer_if bus ();
  fft4_frame_sequencer_if bus1 ();
  fft4_frame_sequencer_if bus15 ();

  fft4_frame_sequencer #(.CORE_LAT(2))  dut   (.clk(clk), .rst(rst), .bus(bus.slave));
  fft4_frame_sequencer #(.CORE_LAT(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
  fft4_frame_sequencer #(.CORE_LAT(15)) dut15 (.clk(clk), .rst(rst), .bus(bus15.slave));

  // 4-point DFT: returns {im bins, re bins}, bin k at [32k+31:32k].
  function automatic logic [255:0] dft4(input logic [127:0] xr, input logic [127:0] xi);
    logic [31:0] r0, r1, r2, r3, i0, i1, i2, i3;
    logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3;
    r0 = xr[31:0];  r1 = xr[63:32];  r2 = xr[95:64];  r3 = xr[127:96];
    i0 = xi[31:0];  i1 = xi[63:32];  i2 = xi[95:64];  i3 = xi[127:96];
    a0 = r0 + r1 + r2 + r3;  b0 = i0 + i1 + i2 + i3;
    a1 = r0 + i1 - r2 - i3;  b1 = i0 - r1 - i2 + r3;
    a2 = r0 - r1 + r2 - r3;  b2 = i0 - i1 + i2 - i3;
    a3 = r0 - i1 - r2 + i3;  b3 = i0 + r1 - i2 - r3;
    return {b3, b2, b1, b0, a3, a2, a1, a0};
  endfunction

  assign {bus.core_im_X, bus.core_re_X}     = dft4(bus.core_re_x, bus.core_im_x);
  assign {bus1.core_im_X, bus1.core_re_X}   = dft4(bus1.core_re_x, bus1.core_im_x);
  assign {bus15.core_im_X, bus15.core_re_X} = dft4(bus15.core_re_x, bus15.core_im_x);

  assign bus1.in_valid   = bus.in_valid;   assign bus15.in_valid  = bus.in_valid;
  assign bus1.in_re      = bus.in_re;      assign bus15.in_re     = bus.in_re;
  assign bus1.in_im      = bus.in_im;      assign bus15.in_im     = bus.in_im;
  assign bus1.flush      = bus.flush;      assign bus15.flush     = bus.flush;
  assign bus1.out_ready  = bus.out_ready;  assign bus15.out_ready = bus.out_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: samples of the frame being built, finished frames,
  // and bins observed on the output handshake.
  logic [31:0]  pend_re[$], pend_im[$];
  logic [127:0] exp_re[$], exp_im[$];
  logic [31:0]  obs_re[$], obs_im[$];
  logic [1:0]   obs_bin[$];
  logic         obs_last[$];
  int           obs_total;
  logic         last_acc;

  task automatic model_accept(input logic [31:0] re, input logic [31:0] im);
    pend_re.push_back(re);
    pend_im.push_back(im);
    if (pend_re.size() == 4) begin
      exp_re.push_back({pend_re[3], pend_re[2], pend_re[1], pend_re[0]});
      exp_im.push_back({pend_im[3], pend_im[2], pend_im[1], pend_im[0]});
      repeat (HOP) begin
        void'(pend_re.pop_front());
        void'(pend_im.pop_front());
      end
    end
  endtask

  // Expected {bin, last, re, im} of the i-th observed bin.
  function automatic logic [66:0] exp_obs(input int i);
    int f = i / 4;
    int k = i % 4;
    logic [255:0] x;
    if (f >= exp_re.size()) return 'x;
    x = dft4(exp_re[f], exp_im[f]);
    return {2'(k), (k == 3), x[32*k +: 32], x[128 + 32*k +: 32]};
  endfunction

  task automatic clear_model();
    pend_re.delete(); pend_im.delete();
    exp_re.delete();  exp_im.delete();
    obs_re.delete();  obs_im.delete(); obs_bin.delete(); obs_last.delete();
    obs_total = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic v, input logic [31:0] re, input logic [31:0] im,
                       input logic fl, input logic rdy);
    bus.in_valid  = v;
    bus.in_re     = re;
    bus.in_im     = im;
    bus.flush     = fl;
    bus.out_ready = rdy;
    #1;
    last_acc = 1'b0;
    if (bus.in_ready) begin
      if (fl) begin
        pend_re.delete(); pend_im.delete();
      end else if (v) begin
        last_acc = 1'b1;
        model_accept(re, im);
      end
    end
    if (bus.out_valid && rdy) begin
      obs_re.push_back(bus.out_re);
      obs_im.push_back(bus.out_im);
      obs_bin.push_back(bus.out_bin);
      obs_last.push_back(bus.out_last);
      obs_total++;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // Drain outstanding bins, then flush any partial frame.
  task automatic settle();
    int c;
    for (c = 0; c < 200; c++) begin
      if (!bus.out_valid && bus.in_ready) break;
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    end
    if (c == 200) begin
      n_cmp++; n_err++;
      $display("FAIL settle_timeout: out_valid=%0b in_ready=%0b required idle", bus.out_valid, bus.in_ready);
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
  endtask

  task automatic drain4();
    for (int c = 0; c < 60 && obs_re.size() < 4; c++)
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b want 0", bus.out_last); end
    n_cmp++; if (bus.frame_idx !== 16'd0) begin n_err++; $display("FAIL rst_frame_idx: got %h want 0", bus.frame_idx); end
    n_cmp++; if (bus.out_bin !== 2'd0) begin n_err++; $display("FAIL rst_out_bin: got %h want 0", bus.out_bin); end
    n_cmp++; if ({bus.core_re_x, bus.core_im_x} !== 256'd0) begin n_err++; $display("FAIL rst_core_x: got %h_%h want 0", bus.core_re_x, bus.core_im_x); end
  endtask

  task automatic test_basic();
    logic [31:0] want_re[4] = '{32'd10, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] want_im[4] = '{32'd0, 32'd2, 32'd0, 32'hFFFF_FFFE};
    int k;
    reset_dut();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i + 1), 32'd0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.core_re_x !== 128'h00000004_00000003_00000002_00000001 || bus.core_im_x !== 128'd0) begin
      n_err++; $display("FAIL basic_core_x: got %h want 00000004000000030000000200000001", bus.core_re_x);
    end
    for (k = 0; k < 40 && !bus.out_valid; k++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    n_cmp++; if (k + 1 != 3) begin n_err++; $display("FAIL basic_latency: got %0d want 3", k + 1); end
    drain4();
    n_cmp++; if (obs_re.size() != 4) begin n_err++; $display("FAIL basic_count: got %0d want 4", obs_re.size()); end
    for (int i = 0; i < obs_re.size() && i < 4; i++) begin
      n_cmp++;
      if ({obs_bin[i], obs_last[i], obs_re[i], obs_im[i]} !== {2'(i), (i == 3), want_re[i], want_im[i]}) begin
        n_err++;
        $display("FAIL basic_bin%0d: got bin=%0d last=%b %h/%h want bin=%0d last=%b %h/%h", i,
                 obs_bin[i], obs_last[i], obs_re[i], obs_im[i], i, (i == 3), want_re[i], want_im[i]);
      end
    end
    n_cmp++; if (bus.frame_idx !== 16'd1) begin n_err++; $display("FAIL basic_frame_idx: got %0d want 1", bus.frame_idx); end
    clear_model();
  endtask

  task automatic test_backpressure();
    logic        prev_v, prev_r;
    logic [65:0] prev_d;
    logic        rdy;
    settle();
    exp_re.delete(); exp_im.delete(); obs_re.delete(); obs_im.delete(); obs_bin.delete(); obs_last.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    for (int c = 0; c < 80 && obs_re.size() < 4; c++) begin
      rdy = c[0];
      if (prev_v && !prev_r) begin
        n_cmp++;
        if ({bus.out_valid, bus.out_bin, bus.out_re, bus.out_im} !== {1'b1, prev_d}) begin
          n_err++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", bus.out_valid,
                            {bus.out_bin, bus.out_re, bus.out_im}, prev_d);
        end
      end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
      prev_v = bus.out_valid; prev_r = rdy; prev_d = {bus.out_bin, bus.out_re, bus.out_im};
      cycle(1'b1, $urandom, $urandom, 1'b0, rdy);
    end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_after: got %b want 1", bus.in_ready); end
    n_cmp++; if (obs_re.size() != 4 * exp_re.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", obs_re.size(), 4 * exp_re.size()); end
    for (int i = 0; i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_bin[i], obs_last[i], obs_re[i], obs_im[i]} !== exp_obs(i)) begin
        n_err++; $display("FAIL bp_bin%0d: got %h want %h", i, {obs_bin[i], obs_last[i], obs_re[i], obs_im[i]}, exp_obs(i));
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] s[7];
    settle();
    exp_re.delete(); exp_im.delete(); obs_re.delete(); obs_im.delete(); obs_bin.delete(); obs_last.delete();
    for (int i = 0; i < 7; i++) s[i] = $urandom;
    cycle(1'b1, s[0], 32'd1, 1'b0, 1'b1);
    cycle(1'b1, s[1], 32'd2, 1'b0, 1'b1);
    cycle(1'b1, s[2], 32'd3, 1'b1, 1'b1);
    for (int i = 3; i < 7; i++) cycle(1'b1, s[i], 32'(i), 1'b0, 1'b1);
    n_cmp++;
    if (bus.core_re_x !== {s[6], s[5], s[4], s[3]}) begin
      n_err++; $display("FAIL flush_frame: got %h want %h", bus.core_re_x, {s[6], s[5], s[4], s[3]});
    end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    drain4();
    n_cmp++; if (obs_re.size() != 4 * exp_re.size()) begin n_err++; $display("FAIL flush_count: got %0d want %0d", obs_re.size(), 4 * exp_re.size()); end
    for (int i = 0; i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_bin[i], obs_last[i], obs_re[i], obs_im[i]} !== exp_obs(i)) begin
        n_err++; $display("FAIL flush_bin%0d: got %h want %h", i, {obs_bin[i], obs_last[i], obs_re[i], obs_im[i]}, exp_obs(i));
      end
    end
  endtask

  task automatic test_async_reset();
    settle();
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    for (int c = 0; c < 40 && !bus.out_valid; c++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    n_cmp++; if ({bus.out_valid, bus.out_bin} !== 3'b101) begin n_err++; $display("FAIL ar_on_bin1: got v=%b bin=%0d want v=1 bin=1", bus.out_valid, bus.out_bin); end
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ar_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL ar_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.frame_idx !== 16'd0) begin n_err++; $display("FAIL ar_frame_idx: got %0d want 0", bus.frame_idx); end
    n_cmp++; if (bus.core_re_x !== 128'd0) begin n_err++; $display("FAIL ar_core_x: got %h want 0", bus.core_re_x); end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1);
    drain4();
    n_cmp++; if (obs_re.size() != 4) begin n_err++; $display("FAIL ar_count: got %0d want 4", obs_re.size()); end
    for (int i = 0; i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_bin[i], obs_last[i], obs_re[i], obs_im[i]} !== exp_obs(i)) begin
        n_err++; $display("FAIL ar_bin%0d: got %h want %h", i, {obs_bin[i], obs_last[i], obs_re[i], obs_im[i]}, exp_obs(i));
      end
    end
    n_cmp++; if (bus.frame_idx !== 16'd1) begin n_err++; $display("FAIL ar_frame_idx_after: got %0d want 1", bus.frame_idx); end
  endtask

  // Samples 1..8: hop 2 gives three frames, hop 4 gives two.
  task automatic test_hop();
    logic [127:0] want_f[3];
    int           want_a[3];
    int           want_n;
    logic [127:0] got_f[3];
    int           got_a[3];
    int           idx, nacc, nf;
    logic         was_rdy;
`ifdef STFT_OVERLAP_EN
    want_n = 3;
    want_f[0] = 128'h00000004_00000003_00000002_00000001; want_a[0] = 4;
    want_f[1] = 128'h00000006_00000005_00000004_00000003; want_a[1] = 2;
    want_f[2] = 128'h00000008_00000007_00000006_00000005; want_a[2] = 2;
`else
    want_n = 2;
    want_f[0] = 128'h00000004_00000003_00000002_00000001; want_a[0] = 4;
    want_f[1] = 128'h00000008_00000007_00000006_00000005; want_a[1] = 4;
    want_f[2] = 128'd0;                                  want_a[2] = 0;
`endif
    reset_dut();
    idx = 0; nacc = 0; nf = 0;
    got_f = '{default: '0}; got_a = '{default: 0};
    for (int c = 0; c < 200; c++) begin
      was_rdy = bus.in_ready;
      cycle(idx < 8, 32'(idx + 1), 32'd0, 1'b0, 1'b1);
      if (last_acc) begin idx++; nacc++; end
      if (was_rdy && !bus.in_ready) begin
        if (nf < 3) begin got_f[nf] = bus.core_re_x; got_a[nf] = nacc; end
        nf++; nacc = 0;
      end
      if (idx == 8 && nf >= want_n && bus.in_ready) break;
    end
    n_cmp++; if (nf != want_n) begin n_err++; $display("FAIL hop_frames: got %0d want %0d", nf, want_n); end
    for (int i = 0; i < want_n; i++) begin
      n_cmp++;
      if (got_f[i] !== want_f[i] || got_a[i] != want_a[i]) begin
        n_err++; $display("FAIL hop_frame%0d: got %h after %0d accepts want %h after %0d", i, got_f[i], got_a[i], want_f[i], want_a[i]);
      end
    end
    n_cmp++; if (bus.frame_idx !== 16'(want_n)) begin n_err++; $display("FAIL hop_frame_idx: got %0d want %0d", bus.frame_idx, want_n); end
    for (int i = 0; i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_bin[i], obs_last[i], obs_re[i], obs_im[i]} !== exp_obs(i)) begin
        n_err++; $display("FAIL hop_bin%0d: got %h want %h", i, {obs_bin[i], obs_last[i], obs_re[i], obs_im[i]}, exp_obs(i));
      end
    end
  endtask

  task automatic test_latency();
    int           lat_m, lat_1, lat_15;
    logic [255:0] held;
    logic         held_ok;
    reset_dut();
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    held = {bus15.core_re_x, bus15.core_im_x};
    held_ok = 1'b1;
    lat_m = -1; lat_1 = -1; lat_15 = -1;
    for (int k = 0; k < 24; k++) begin
      if (lat_m  < 0 && bus.out_valid)   lat_m  = k + 1;
      if (lat_1  < 0 && bus1.out_valid)  lat_1  = k + 1;
      if (lat_15 < 0 && bus15.out_valid) lat_15 = k + 1;
      if (!bus15.out_valid && {bus15.core_re_x, bus15.core_im_x} !== held) held_ok = 1'b0;
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    end
    n_cmp++; if (lat_1 != 2)   begin n_err++; $display("FAIL lat_core1: got %0d want 2", lat_1); end
    n_cmp++; if (lat_15 != 16) begin n_err++; $display("FAIL lat_core15: got %0d want 16", lat_15); end
    n_cmp++; if (lat_m != 3)   begin n_err++; $display("FAIL lat_core2: got %0d want 3", lat_m); end
    n_cmp++; if (held_ok !== 1'b1) begin n_err++; $display("FAIL lat_core_bus_stable: got %b want 1", held_ok); end
    reset_dut();
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 1500; c++)
      cycle(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 40) == 0, ($urandom % 3) != 0);
    settle();
    n_cmp++; if (obs_re.size() != 4 * exp_re.size()) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", obs_re.size(), 4 * exp_re.size()); end
    n_cmp++; if (exp_re.size() < 20) begin n_err++; $display("FAIL rnd_frames: got %0d want >=20", exp_re.size()); end
    for (int i = 0; i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_bin[i], obs_last[i], obs_re[i], obs_im[i]} !== exp_obs(i)) begin
        n_err++; $display("FAIL rnd_bin%0d: got %h want %h", i, {obs_bin[i], obs_last[i], obs_re[i], obs_im[i]}, exp_obs(i));
      end
    end
    n_cmp++; if (bus.frame_idx !== 16'(obs_total / 4)) begin n_err++; $display("FAIL rnd_frame_idx: got %0d want %0d", bus.frame_idx, obs_total / 4); end
  endtask

  initial begin
    clear_model();
    last_acc = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_hop();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fft4_frame_sequencer.md
# fft4_frame_sequencer

Sequencing controller for the shared 4-point complex FFT core in the STFT path. It collects a stream of complex 32-bit samples into 4-sample frames and holds each frame stable on the core inputs for a programmable settle time. It then captures the core outputs and streams bins X0..X3 out over a valid/ready handshake. It sits between the windowed sample source and the spectrum sink, and owns the only instance of the butterfly network.

## Interface
Parameters:
- CORE_LAT, 2: cycles the core inputs are held before outputs are captured; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of any partial frame.
- in_valid  input  1  sample valid.
- in_ready  output  1  sample accepted when in_valid & in_ready.
- in_re, in_im  input  32  sample real/imag word (posit/FP bits, opaque to this block).
- core_re_x, core_im_x  output  128  frame to core; slot k at bits [32k+31:32k].
- core_re_X, core_im_X  input  128  core results; bin k at bits [32k+31:32k].
- out_valid  output  1  bin valid.
- out_ready  input  1  sink ready.
- out_re, out_im  output  32  current bin.
- out_bin  output  2  index of the current bin.
- out_last  output  1  high with bin 3.
- frame_idx  output  16  count of completed frames; wraps at 0xFFFF→0.

## Operation
- Frame registers: 4 complex slots drive core_re_x/core_im_x directly. Slots change only on an accepted sample.
- Result registers: 4 complex slots, loaded from core_re_X/core_im_X on the capture cycle.
- FSM states:
  - FILL: in_ready=1. Each accept writes slot fill_cnt and increments fill_cnt. The accept that fills slot 3 moves the FSM to WAIT and clears lat_cnt.
  - WAIT: in_ready=0, out_valid=0, lat_cnt increments each cycle. When lat_cnt==CORE_LAT-1, the results are captured and the FSM moves to DRAIN with bin=0.
  - DRAIN: out_valid=1; out_re/out_im/out_bin reflect result slot bin. An out handshake advances bin. The handshake on bin 3 increments frame_idx and moves the FSM to FILL.
- Re-entry to FILL without overlap: fill_cnt=0.
- Backpressure: out_ready=0 holds out_* stable with out_valid high. in_valid is ignored outside FILL.
- flush:
  - In FILL: sets fill_cnt=0 and drops any sample presented the same cycle. Flush wins over in_valid.
  - In WAIT/DRAIN: no effect. The frame in flight always completes.
- Reset values: FSM=FILL, fill_cnt=0, lat_cnt=0, bin=0, frame_idx=0, all frame/result slots=0, in_ready=1, out_valid=0, out_last=0. Reset mid-frame discards all partial state.

## Timing
- Accept of slot 3 at edge T → core inputs stable from T. Capture occurs at edge T+CORE_LAT. out_valid first rises in the cycle after that edge, i.e. CORE_LAT+1 cycles after the final accept.
- Minimum frame period without stalls: 4 (fill) + CORE_LAT + 4 (drain) cycles.
- in_ready is combinational from state only and never depends on in_valid. out_valid does not depend on out_ready.
- The core is combinational. The CORE_LAT cycles are declared as a multicycle path from the frame registers to the result registers.

## Configuration
- STFT_OVERLAP_EN defined: 50% overlap (hop 2). At the DRAIN→FILL transition, slots 2,3 are copied to slots 0,1 and fill_cnt=2. The first frame after reset or flush still needs 4 samples. flush clears fill_cnt to 0.
- Undefined: hop 4. Every frame needs 4 fresh samples and slots are not copied.

## Test plan
- Reset then 4 back-to-back samples re/im = (1,0),(2,0),(3,0),(4,0), CORE_LAT=2, core modelled as a 4-point DFT → core_re_x=0x00000004_00000003_00000002_00000001; out_valid 3 cycles after the 4th accept. Bins in order: X0=(10,0), X1=(-2,2), X2=(-2,0), X3=(-2,-2); out_last only on bin 3; frame_idx=1.
- out_ready toggled 0/1 every cycle during DRAIN → each bin held until its handshake; no bin skipped or repeated. in_ready stays 0 until after the bin-3 handshake.
- Samples A,B accepted, then flush asserted together with in_valid for C → C dropped, fill_cnt=0. The next 4 samples form the frame and slot 0 holds the first of them.
- rst asserted asynchronously mid-DRAIN on bin 1 → out_valid=0 immediately, frame_idx=0, in_ready=1. The next frame is unaffected by stale data.
- STFT_OVERLAP_EN with input 1..8 → frames [1,2,3,4], [3,4,5,6], [5,6,7,8]; the second frame needs only 2 accepts; frame_idx=3.
- CORE_LAT=1 and CORE_LAT=15 → out_valid rises exactly 2 and 16 cycles after the final accept respectively. Core input bus is constant throughout WAIT.
